// File: rtl/kv_cache_pkg.sv
// Shared types and width helpers for the set-associative cache miss controller.
package kv_cache_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLookup,
        StWbReq,
        StWbData,
        StFillReq,
        StFillData,
        StResp
    } state_e;

    // A beat is one 32-bit word.
    localparam int unsigned WordBytes = 4;
    localparam int unsigned WordOffW  = 2;

    function automatic int unsigned index_w(int unsigned line_num, int unsigned way_num);
        return $clog2(line_num / way_num);
    endfunction

    function automatic int unsigned off_w(int unsigned line_beats);
        return $clog2(line_beats) + WordOffW;
    endfunction

    function automatic int unsigned tag_w(int unsigned addr_width, int unsigned line_num,
                                          int unsigned way_num, int unsigned line_beats);
        return addr_width - index_w(line_num, way_num) - off_w(line_beats);
    endfunction

endpackage

// File: rtl/kv_onehot_pick.sv
// Lowest-set-bit one-hot select; an all-zero input selects the MSB way.
module kv_onehot_pick #(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0] vec_i,
    output logic [N-1:0] onehot_o
);

    logic [N-1:0] lowest;

    // Two's-complement trick isolates the lowest set bit.
    assign lowest   = vec_i & (~vec_i + 1'b1);
    assign onehot_o = (|vec_i) ? lowest : {1'b1, {(N-1){1'b0}}};

endmodule

// File: rtl/kv_cache_miss_ctrl.sv
// Sequencing FSM for one set-associative cache: hit/LRU update, victim writeback, refill.
module kv_cache_miss_ctrl
    import kv_cache_pkg::*;
#(
    parameter int unsigned WAY_NUM    = 4,
    parameter int unsigned LINE_NUM   = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned LINE_BEATS = 4,
    localparam int unsigned INDEX_W   = index_w(LINE_NUM, WAY_NUM),
    localparam int unsigned BEAT_W    = $clog2(LINE_BEATS),
    localparam int unsigned OFF_W     = off_w(LINE_BEATS),
    localparam int unsigned TAG_W     = tag_w(ADDR_WIDTH, LINE_NUM, WAY_NUM, LINE_BEATS)
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    output logic                  o_resp_valid,
    output logic                  o_resp_hit,
    input  logic [WAY_NUM-1:0]    i_tag_hitway,
    input  logic [WAY_NUM-1:0]    i_victim_dirty,
    input  logic [TAG_W-1:0]      i_victim_tag,
    output logic [INDEX_W-1:0]    o_lru_index,
    output logic [WAY_NUM-1:0]    o_lru_hitway,
    output logic                  o_lru_update,
    input  logic [WAY_NUM-1:0]    i_lru_killmask,
    output logic                  o_mem_req_valid,
    input  logic                  i_mem_req_ready,
    output logic                  o_mem_req_we,
    output logic [ADDR_WIDTH-1:0] o_mem_req_addr,
    input  logic                  i_mem_beat,
    output logic                  o_fill_we,
    output logic [WAY_NUM-1:0]    o_fill_way,
    output logic [BEAT_W-1:0]     o_fill_beat
);

    localparam int unsigned LINE_W = ADDR_WIDTH - OFF_W;
    localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(LINE_BEATS - 1);

    state_e              state_q, state_d;
    logic [LINE_W-1:0]   line_q, line_d;
    logic [WAY_NUM-1:0]  victim_q, victim_d;
    logic [BEAT_W-1:0]   beat_q, beat_d;
    logic                resp_hit_q, resp_hit_d;

    logic [WAY_NUM-1:0]  hit_pick;
    logic [WAY_NUM-1:0]  victim_pick;
    logic [INDEX_W-1:0]  index;
    logic [TAG_W-1:0]    req_tag;
    logic                unused_addr_bits;

    // Only the line address is kept; the byte offset within the line is irrelevant here.
    assign unused_addr_bits = ^i_req_addr[OFF_W-1:0];

    assign index       = line_q[INDEX_W-1:0];
    assign req_tag     = line_q[LINE_W-1:INDEX_W];
    assign o_lru_index = index;
    assign o_fill_beat = beat_q;

    kv_onehot_pick #(.N(WAY_NUM)) u_hit_pick (
        .vec_i    (i_tag_hitway),
        .onehot_o (hit_pick)
    );

    kv_onehot_pick #(.N(WAY_NUM)) u_victim_pick (
        .vec_i    (i_lru_killmask),
        .onehot_o (victim_pick)
    );

    // State and request-context registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= StIdle;
            line_q     <= '0;
            victim_q   <= '0;
            beat_q     <= '0;
            resp_hit_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            line_q     <= line_d;
            victim_q   <= victim_d;
            beat_q     <= beat_d;
            resp_hit_q <= resp_hit_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d         = state_q;
        line_d          = line_q;
        victim_d        = victim_q;
        beat_d          = beat_q;
        resp_hit_d      = resp_hit_q;
        o_req_ready     = 1'b0;
        o_resp_valid    = 1'b0;
        o_resp_hit      = 1'b0;
        o_lru_update    = 1'b0;
        o_lru_hitway    = '0;
        o_mem_req_valid = 1'b0;
        o_mem_req_we    = 1'b0;
        o_mem_req_addr  = '0;
        o_fill_we       = 1'b0;
        o_fill_way      = '0;

        unique case (state_q)
            StIdle: begin
                o_req_ready = 1'b1;
                if (i_req_valid) begin
                    line_d  = i_req_addr[ADDR_WIDTH-1:OFF_W];
                    state_d = StLookup;
                end
            end
            StLookup: begin
                if (|i_tag_hitway) begin
                    o_lru_update = 1'b1;
                    o_lru_hitway = hit_pick;
                    resp_hit_d   = 1'b1;
                    state_d      = StResp;
                end else begin
                    victim_d   = victim_pick;
                    resp_hit_d = 1'b0;
                    state_d    = (|(victim_pick & i_victim_dirty)) ? StWbReq : StFillReq;
                end
            end
            StWbReq: begin
                o_mem_req_valid = 1'b1;
                o_mem_req_we    = 1'b1;
                o_mem_req_addr  = {i_victim_tag, index, {OFF_W{1'b0}}};
                o_fill_way      = victim_q;
                if (i_mem_req_ready) state_d = StWbData;
            end
            StWbData: begin
                o_fill_way = victim_q;
                if (i_mem_beat) begin
                    if (beat_q == LastBeat) begin
                        beat_d  = '0;
                        state_d = StFillReq;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StFillReq: begin
                o_mem_req_valid = 1'b1;
                o_mem_req_addr  = {req_tag, index, {OFF_W{1'b0}}};
                o_fill_way      = victim_q;
                if (i_mem_req_ready) state_d = StFillData;
            end
            StFillData: begin
                o_fill_way = victim_q;
                if (i_mem_beat) begin
                    o_fill_we = 1'b1;
                    if (beat_q == LastBeat) begin
                        beat_d       = '0;
                        o_lru_update = 1'b1;
                        o_lru_hitway = victim_q;
                        resp_hit_d   = 1'b0;
                        state_d      = StResp;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            StResp: begin
                o_resp_valid = 1'b1;
                o_resp_hit   = resp_hit_q;
                state_d      = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_kv_cache_miss_ctrl.sv
// Transaction-level bench for kv_cache_miss_ctrl with a queue-free reference model.
module tb_kv_cache_miss_ctrl;

    logic        clk = 1'b0;
    logic        i_rstn;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_addr;
    logic        o_resp_valid;
    logic        o_resp_hit;
    logic [3:0]  i_tag_hitway;
    logic [3:0]  i_victim_dirty;
    logic [23:0] i_victim_tag;
    logic [3:0]  o_lru_index;
    logic [3:0]  o_lru_hitway;
    logic        o_lru_update;
    logic [3:0]  i_lru_killmask;
    logic        o_mem_req_valid;
    logic        i_mem_req_ready;
    logic        o_mem_req_we;
    logic [31:0] o_mem_req_addr;
    logic        i_mem_beat;
    logic        o_fill_we;
    logic [3:0]  o_fill_way;
    logic [1:0]  o_fill_beat;

    int checks = 0;
    int errors = 0;
    int lru_cnt = 0;
    int bad_hitway = 0;
    int wb_we_bad = 0;
    bit in_wb = 1'b0;

    always #5 clk = ~clk;

    kv_cache_miss_ctrl dut (
        .i_clk           (clk),
        .i_rstn          (i_rstn),
        .i_req_valid     (i_req_valid),
        .o_req_ready     (o_req_ready),
        .i_req_addr      (i_req_addr),
        .o_resp_valid    (o_resp_valid),
        .o_resp_hit      (o_resp_hit),
        .i_tag_hitway    (i_tag_hitway),
        .i_victim_dirty  (i_victim_dirty),
        .i_victim_tag    (i_victim_tag),
        .o_lru_index     (o_lru_index),
        .o_lru_hitway    (o_lru_hitway),
        .o_lru_update    (o_lru_update),
        .i_lru_killmask  (i_lru_killmask),
        .o_mem_req_valid (o_mem_req_valid),
        .i_mem_req_ready (i_mem_req_ready),
        .o_mem_req_we    (o_mem_req_we),
        .o_mem_req_addr  (o_mem_req_addr),
        .i_mem_beat      (i_mem_beat),
        .o_fill_we       (o_fill_we),
        .o_fill_way      (o_fill_way),
        .o_fill_beat     (o_fill_beat)
    );

    // Mid-cycle monitor: LRU strobes per request, stray hitway, fill writes during writeback.
    always @(negedge clk) begin
        if (o_lru_update) lru_cnt++;
        if (!o_lru_update && o_lru_hitway != 4'b0) bad_hitway++;
        if (in_wb && o_fill_we) wb_we_bad++;
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference way choice: first set bit scanning upward, top way when nothing is set.
    function automatic logic [3:0] lowest_way(input logic [3:0] v);
        for (int i = 0; i < 4; i++) begin
            if (v[i]) return 4'(1 << i);
        end
        return 4'b1000;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic burst(input bit we, input logic [31:0] exp_addr, input logic [3:0] v,
                         input logic [3:0] idx, input int wait_n, input int abort_beat,
                         output bit aborted);
        aborted = 1'b0;
        for (int c = 0; c <= wait_n; c++) begin
            i_mem_req_ready = (c == wait_n);
            i_mem_beat      = 1'($urandom_range(0, 1));
            #1;
            check_eq("req_valid", 64'(o_mem_req_valid), 64'd1);
            check_eq("req_we", 64'(o_mem_req_we), 64'(we));
            check_eq("req_addr", 64'(o_mem_req_addr), 64'(exp_addr));
            check_eq("req_fill_we", 64'(o_fill_we), 64'd0);
            check_eq("req_index", 64'(o_lru_index), 64'(idx));
            tick();
        end
        i_mem_req_ready = 1'b0;
        i_mem_beat      = 1'b0;
        for (int b = 0; b < 4; b++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            for (int g = 0; g < gap; g++) begin
                i_mem_beat = 1'b0;
                #1;
                check_eq("gap_fill_we", 64'(o_fill_we), 64'd0);
                check_eq("gap_beat", 64'(o_fill_beat), 64'(b));
                check_eq("gap_mem_valid", 64'(o_mem_req_valid), 64'd0);
                tick();
            end
            if (b == abort_beat) begin
                i_mem_beat = 1'b1;
                i_rstn     = 1'b0;
                #1;
                check_eq("rst_ready", 64'(o_req_ready), 64'd1);
                check_eq("rst_fill_we", 64'(o_fill_we), 64'd0);
                check_eq("rst_mem_valid", 64'(o_mem_req_valid), 64'd0);
                check_eq("rst_beat", 64'(o_fill_beat), 64'd0);
                aborted = 1'b1;
                return;
            end
            i_mem_beat = 1'b1;
            #1;
            check_eq("beat_num", 64'(o_fill_beat), 64'(b));
            check_eq("beat_fill_we", 64'(o_fill_we), 64'(!we));
            check_eq("beat_way", 64'(o_fill_way), 64'(v));
            check_eq("beat_lru_upd", 64'(o_lru_update), 64'(!we && b == 3));
            if (!we && b == 3) check_eq("fill_lru_way", 64'(o_lru_hitway), 64'(v));
            tick();
            i_mem_beat = 1'b0;
        end
    endtask

    task automatic do_req(input logic [31:0] addr, input logic [3:0] hitvec,
                          input logic [3:0] kill, input logic [3:0] dirty,
                          input logic [23:0] vtag, input int wait_n, input int abort_beat);
        logic [3:0] idx;
        logic [3:0] v;
        int         lru0;
        bit         aborted;
        idx  = addr[7:4];
        lru0 = lru_cnt;
        i_req_valid    = 1'b1;
        i_req_addr     = addr;
        i_tag_hitway   = hitvec;
        i_lru_killmask = kill;
        i_victim_dirty = dirty;
        i_victim_tag   = vtag;
        #1;
        check_eq("idle_ready", 64'(o_req_ready), 64'd1);
        tick();
        i_req_valid = 1'b0;
        i_req_addr  = $urandom;
        #1;
        check_eq("lk_ready", 64'(o_req_ready), 64'd0);
        check_eq("lk_index", 64'(o_lru_index), 64'(idx));
        check_eq("lk_mem_valid", 64'(o_mem_req_valid), 64'd0);
        check_eq("lk_lru_upd", 64'(o_lru_update), 64'(hitvec != 4'b0));
        if (hitvec != 4'b0) begin
            check_eq("lk_lru_way", 64'(o_lru_hitway), 64'(lowest_way(hitvec)));
            tick();
        end else begin
            v = lowest_way(kill);
            tick();
            if ((v & dirty) != 4'b0) begin
                in_wb = 1'b1;
                burst(1'b1, {vtag, idx, 4'b0}, v, idx, wait_n, -1, aborted);
                in_wb = 1'b0;
            end
            burst(1'b0, {addr[31:4], 4'b0}, v, idx, wait_n, abort_beat, aborted);
            if (aborted) begin
                #2;
                i_rstn     = 1'b1;
                i_mem_beat = 1'b0;
                tick();
                #1;
                check_eq("post_rst_ready", 64'(o_req_ready), 64'd1);
                check_eq("post_rst_valid", 64'(o_mem_req_valid), 64'd0);
                tick();
                return;
            end
        end
        #1;
        check_eq("resp_valid", 64'(o_resp_valid), 64'd1);
        check_eq("resp_hit", 64'(o_resp_hit), 64'(hitvec != 4'b0));
        check_eq("resp_index", 64'(o_lru_index), 64'(idx));
        check_eq("resp_mem_valid", 64'(o_mem_req_valid), 64'd0);
        tick();
        check_eq("lru_once", 64'(lru_cnt - lru0), 64'd1);
    endtask

    initial begin
        i_rstn          = 1'b0;
        i_req_valid     = 1'b0;
        i_req_addr      = '0;
        i_tag_hitway    = '0;
        i_victim_dirty  = '0;
        i_victim_tag    = '0;
        i_lru_killmask  = '0;
        i_mem_req_ready = 1'b0;
        i_mem_beat      = 1'b0;
        tick();
        tick();
        #1;
        check_eq("rst_ready0", 64'(o_req_ready), 64'd1);
        check_eq("rst_resp0", 64'(o_resp_valid), 64'd0);
        check_eq("rst_lru0", 64'(o_lru_update), 64'd0);
        check_eq("rst_mem0", 64'(o_mem_req_valid), 64'd0);
        check_eq("rst_addr0", 64'(o_mem_req_addr), 64'd0);
        check_eq("rst_beat0", 64'(o_fill_beat), 64'd0);
        check_eq("rst_way0", 64'(o_fill_way), 64'd0);
        check_eq("rst_index0", 64'(o_lru_index), 64'd0);
        i_rstn = 1'b1;
        tick();

        do_req(32'h0000_0040, 4'b0100, 4'b0000, 4'b0000, 24'h0, 1, -1);
        do_req(32'h1234_5678, 4'b0000, 4'b1000, 4'b0000, 24'h0, 2, -1);
        do_req(32'h0000_0A30, 4'b0000, 4'b0010, 4'b0010, 24'h012345, 1, -1);
        do_req(32'hCAFE_0090, 4'b0000, 4'b0000, 4'b0000, 24'h0, 0, -1);
        do_req(32'h8000_00F0, 4'b0000, 4'b0001, 4'b0001, 24'hABCDEF, 5, -1);
        do_req(32'h0000_0120, 4'b1110, 4'b0000, 4'b1111, 24'h0, 1, -1);
        do_req(32'h5555_5550, 4'b0000, 4'b0100, 4'b0000, 24'h0, 1, 2);
        do_req(32'h0000_0040, 4'b0001, 4'b0000, 4'b0000, 24'h0, 1, -1);

        for (int n = 0; n < 40; n++) begin
            logic [3:0] hv;
            hv = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
            do_req($urandom, hv, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                   24'($urandom), int'($urandom_range(0, 4)), -1);
        end

        check_eq("hitway_idle_zero", 64'(bad_hitway), 64'd0);
        check_eq("wb_no_fill_we", 64'(wb_we_bad), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
